uarc_send_buffer: RTL

UARC_SEND_BUFFER -- requirements
Module: uarc_send_buffer

---
 rtl/uarc_send_buffer_pkg.sv | 21 ++
 rtl/uarc_send_buffer_if.sv | 52 +++++
 rtl/uarc_send_buffer_fifo.sv | 71 +++++++
 rtl/uarc_send_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/uarc_send_buffer_pkg.sv
// Shared definitions for the uarc send buffer.
// - uarc_state_e : control FSM states (IDLE, DRAIN, KILL, INCEPT, ACK)
// - entry_width  : width of one FIFO entry, {self_permission, self_address, data}
package uarc_send_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_KILL   = 3'd2,
        ST_INCEPT = 3'd3,
        ST_ACK    = 3'd4
    } uarc_state_e;

    // A FIFO entry carries three words: permission, address and payload.
    localparam int ENTRY_FIELDS = 3;

    function automatic int entry_width(input int word_mag);
        return ENTRY_FIELDS * (1 << word_mag);
    endfunction

endpackage

// File: rtl/uarc_send_buffer_if.sv
// Sender/receiver bundle for the uarc send buffer.
// Sender side : enable, kill/incept/send requests, data and address words in;
//               kill_ack/incept_ack/send_ack out.
// Receiver side: rx_kill/rx_incept/rx_send requests and rx_* words out;
//               rx_kill_ack/rx_incept_ack/rx_send_ack in.
// modport slave  : the buffer itself.
// modport master : whatever drives the sender inputs and receiver acks.
interface uarc_send_buffer_if #(
    parameter int WORD_MAG = 5
);
    localparam int W = 1 << WORD_MAG;

    logic         enable;
    logic         kill;
    logic         incept;
    logic         send;
    logic [W-1:0] data;
    logic [W-1:0] self_permission;
    logic [W-1:0] self_address;
    logic [W-1:0] incept_permission;
    logic [W-1:0] incept_address;
    logic         kill_ack;
    logic         incept_ack;
    logic         send_ack;

    logic         rx_kill;
    logic         rx_incept;
    logic         rx_send;
    logic [W-1:0] rx_data;
    logic [W-1:0] rx_self_permission;
    logic [W-1:0] rx_self_address;
    logic [W-1:0] rx_incept_permission;
    logic [W-1:0] rx_incept_address;
    logic         rx_kill_ack;
    logic         rx_incept_ack;
    logic         rx_send_ack;

    modport slave (
        input  enable, kill, incept, send, data, self_permission, self_address,
               incept_permission, incept_address, rx_kill_ack, rx_incept_ack, rx_send_ack,
        output kill_ack, incept_ack, send_ack, rx_kill, rx_incept, rx_send, rx_data,
               rx_self_permission, rx_self_address, rx_incept_permission, rx_incept_address
    );

    modport master (
        output enable, kill, incept, send, data, self_permission, self_address,
               incept_permission, incept_address, rx_kill_ack, rx_incept_ack, rx_send_ack,
        input  kill_ack, incept_ack, send_ack, rx_kill, rx_incept, rx_send, rx_data,
               rx_self_permission, rx_self_address, rx_incept_permission, rx_incept_address
    );

endinterface

// File: rtl/uarc_send_buffer_fifo.sv
// uarc_fifo: circular FIFO of 2**DEPTH_MAG entries of WIDTH bits.
// Ports: clk, reset (async active-high), push/pop requests, flush (clears
// occupancy), wdata in, rdata (head entry, 0 when empty), full, empty, count.
// A push into a full FIFO is dropped even if a pop happens the same cycle.
module uarc_fifo #(
    parameter int WIDTH     = 96,
    parameter int DEPTH_MAG = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]     rdata,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTH_MAG:0]   count
);
    localparam int                 DEPTH      = 1 << DEPTH_MAG;
    localparam logic [DEPTH_MAG:0] FULL_COUNT = {1'b1, {DEPTH_MAG{1'b0}}};
    localparam logic [DEPTH_MAG:0] CNT_ONE    = (DEPTH_MAG + 1)'(1);
    localparam logic [DEPTH_MAG-1:0] PTR_ONE  = DEPTH_MAG'(1);

    logic [WIDTH-1:0]     mem_r [DEPTH];
    logic [DEPTH_MAG-1:0] wr_ptr_r;
    logic [DEPTH_MAG-1:0] rd_ptr_r;
    logic [DEPTH_MAG:0]   count_r;
    logic                 push_ok_s;
    logic                 pop_ok_s;

    // Status flags, qualified requests and head-entry view.
    always_comb begin
        full      = (count_r == FULL_COUNT);
        empty     = (count_r == '0);
        push_ok_s = push & ~full;
        pop_ok_s  = pop & ~empty;
        rdata     = empty ? '0 : mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uarc_send_buffer.sv
// uarc_send_buffer: queues sender words toward a receiver and sequences
// kill (flush + notify) and incept (drain, then hand over new permission and
// address) operations.
// Ports: clk, reset (async active-high), bus (slave side of
// uarc_send_buffer_if), count (current FIFO occupancy).
module uarc_send_buffer
    import uarc_send_buffer_pkg::*;
#(
    parameter int WORD_MAG = 5,
    parameter int FIFO_MAG = 2
) (
    input  logic                clk,
    input  logic                reset,
    uarc_send_buffer_if.slave   bus,
    output logic [FIFO_MAG:0]   count
);
    localparam int W  = 1 << WORD_MAG;
    localparam int EW = entry_width(WORD_MAG);
    localparam logic [FIFO_MAG:0] CNT_ONE = (FIFO_MAG + 1)'(1);

    uarc_state_e  state_r;
    uarc_state_e  state_nxt_s;
    logic         op_kill_r;
    logic [W-1:0] incept_permission_r;
    logic [W-1:0] incept_address_r;

    logic          kill_req_s;
    logic          incept_req_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          full_s;
    logic          empty_s;
    logic [EW-1:0] head_s;
    logic [EW-1:0] entry_s;

    uarc_fifo #(
        .WIDTH     (EW),
        .DEPTH_MAG (FIFO_MAG)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (entry_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count)
    );

    // Request decode; kill outranks incept, which outranks send.
    always_comb begin
        kill_req_s   = bus.enable & bus.kill;
        incept_req_s = bus.enable & bus.incept & ~bus.kill;
        entry_s      = {bus.self_permission, bus.self_address, bus.data};
        flush_s      = kill_req_s & ((state_r == ST_IDLE) | (state_r == ST_DRAIN));
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (kill_req_s) begin
                    state_nxt_s = ST_KILL;
                end else if (incept_req_s) begin
                    state_nxt_s = empty_s ? ST_INCEPT : ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the last queued word is being popped.
                if (kill_req_s) begin
                    state_nxt_s = ST_KILL;
                end else if (empty_s | (pop_s & (count == CNT_ONE))) begin
                    state_nxt_s = ST_INCEPT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_KILL:   state_nxt_s = bus.rx_kill_ack   ? ST_ACK : ST_KILL;
            ST_INCEPT: state_nxt_s = bus.rx_incept_ack ? ST_ACK : ST_INCEPT;
            ST_ACK:    state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs derived from state; send_ack and pop are combinational handshakes.
    always_comb begin
        bus.send_ack   = kill_req_s ? 1'b0 :
                         (bus.enable & bus.send & ~bus.incept & (state_r == ST_IDLE) & ~full_s);
        bus.rx_send    = ~empty_s & ((state_r == ST_IDLE) | (state_r == ST_DRAIN));
        bus.rx_kill    = (state_r == ST_KILL);
        bus.rx_incept  = (state_r == ST_INCEPT);
        bus.kill_ack   = (state_r == ST_ACK) & op_kill_r;
        bus.incept_ack = (state_r == ST_ACK) & ~op_kill_r;
        push_s         = bus.send_ack;
        pop_s          = bus.rx_send & bus.rx_send_ack;
        bus.rx_data            = head_s[W-1:0];
        bus.rx_self_address    = head_s[2*W-1:W];
        bus.rx_self_permission = head_s[3*W-1:2*W];
        bus.rx_incept_permission = incept_permission_r;
        bus.rx_incept_address    = incept_address_r;
    end

    // Remember which operation is in flight and latch the incept words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_kill_r           <= 1'b0;
            incept_permission_r <= '0;
            incept_address_r    <= '0;
        end else if (flush_s) begin
            op_kill_r <= 1'b1;
        end else if ((state_r == ST_IDLE) && incept_req_s) begin
            op_kill_r           <= 1'b0;
            incept_permission_r <= bus.incept_permission;
            incept_address_r    <= bus.incept_address;
        end else begin
            op_kill_r <= op_kill_r;
        end
    end

endmodule
